alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU behind a valid/ready handshake.
// Most opcodes produce a registered result one edge after acceptance.
// MUL is computed by an iterative shift-add unit over WIDTH cycles, and
// the block does not accept new work while that unit is busy.
//
// state    | meaning
// IDLE     | ready for a request whenever the result slot is free or being consumed
// MUL_BUSY | shift-add multiply in progress, one multiplier bit per cycle
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic [3:0]       flags
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ZERO   = 4'b0000;
    localparam logic [3:0] OP_AND    = 4'b0001;
    localparam logic [3:0] OP_OR     = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_ADD    = 4'b0100;
    localparam logic [3:0] OP_SUB    = 4'b0101;
    localparam logic [3:0] OP_NOT    = 4'b0110;
    localparam logic [3:0] OP_ONES   = 4'b0111;
    localparam logic [3:0] OP_MUL    = 4'b1000;
    localparam logic [3:0] OP_ACC    = 4'b1001;
    localparam logic [3:0] OP_ACCCLR = 4'b1010;
    localparam logic [3:0] OP_SHL    = 4'b1011;
    localparam logic [3:0] OP_SHR    = 4'b1100;

    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_y;
    logic [WIDTH-1:0]     r_y_hi;
    logic [3:0]           r_flags;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_load_alu;
    logic                 w_mul_last;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_accsum;
    logic [SHW-1:0]       w_shamt;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic [WIDTH-1:0]     w_alu_y;
    logic                 w_alu_c;
    logic                 w_alu_v;
    logic                 w_alu_undef;
    logic [3:0]           w_alu_flags;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic                 w_acc_upd;
    logic [WIDTH-1:0]     w_mul_lo;
    logic [WIDTH-1:0]     w_mul_hi;

    // MUL only counts as a real opcode when the multiplier is built in.
    assign w_is_mul   = (sel == OP_MUL) && (MUL_EN != 0);
    assign w_accept   = in_valid && w_ready;
    assign w_load_alu = w_accept && !w_is_mul;
    assign w_mul_last = (r_state == MUL_BUSY) && (r_cnt == MUL_LAST);

    assign w_sum    = {1'b0, A} + {1'b0, B};
    // The extra top bit of the difference is the unsigned borrow.
    assign w_diff   = {1'b0, A} - {1'b0, B};
    assign w_accsum = {1'b0, r_acc} + {1'b0, A};
    assign w_shamt  = B[SHW-1:0];

    assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mul_lo   = w_prod_nxt[WIDTH-1:0];
    assign w_mul_hi   = w_prod_nxt[2*WIDTH-1:WIDTH];

    // Single-cycle datapath: result, carry/overflow and accumulator update per opcode.
    always_comb begin
        w_alu_y     = '0;
        w_alu_c     = 1'b0;
        w_alu_v     = 1'b0;
        w_alu_undef = 1'b0;
        w_acc_nxt   = r_acc;
        w_acc_upd   = 1'b0;
        case (sel)
            OP_ZERO: w_alu_y = '0;
            OP_AND:  w_alu_y = A & B;
            OP_OR:   w_alu_y = A | B;
            OP_XOR:  w_alu_y = A ^ B;
            OP_ADD: begin
                w_alu_y = w_sum[WIDTH-1:0];
                w_alu_c = w_sum[WIDTH];
                w_alu_v = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                w_alu_y = w_diff[WIDTH-1:0];
                w_alu_c = w_diff[WIDTH];
                w_alu_v = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            OP_NOT:  w_alu_y = ~A;
            OP_ONES: w_alu_y = '1;
            OP_ACC: begin
                w_alu_y   = w_accsum[WIDTH-1:0];
                w_alu_c   = w_accsum[WIDTH];
                w_alu_v   = (r_acc[MSB] == A[MSB]) && (w_accsum[MSB] != r_acc[MSB]);
                w_acc_nxt = w_accsum[WIDTH-1:0];
                w_acc_upd = 1'b1;
            end
            OP_ACCCLR: begin
                w_alu_y   = r_acc;
                w_acc_nxt = '0;
                w_acc_upd = 1'b1;
            end
            OP_SHL: w_alu_y = A << w_shamt;
            OP_SHR: w_alu_y = A >> w_shamt;
            // Undefined opcodes, and MUL when the multiplier is not built in.
            default: w_alu_undef = 1'b1;
        endcase
        w_alu_flags = w_alu_undef ? 4'b0001
                                  : {w_alu_y[MSB], (w_alu_y == '0), w_alu_c, w_alu_v};
    end

    // Next-state and handshake ready for the IDLE / MUL_BUSY controller.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !r_out_valid || out_ready;
                if (in_valid && w_ready && w_is_mul) begin
                    w_state_nxt = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (r_cnt == MUL_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift-add multiplier: the multiplicand moves left and the multiplier right, one bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_prod   <= '0;
        end else if (r_state == MUL_BUSY) begin
            r_cnt    <= (r_cnt == MUL_LAST) ? '0 : r_cnt + 1'b1;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= w_prod_nxt;
        end
    end

    // Accumulator changes only on an accepted ACC or ACCCLR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_load_alu && w_acc_upd) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Result slot: loads on a single-cycle op or on the final multiply step, otherwise held until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= '0;
            r_y_hi      <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load_alu) begin
            r_y         <= w_alu_y;
            r_y_hi      <= '0;
            r_flags     <= w_alu_flags;
            r_out_valid <= 1'b1;
        end else if (w_mul_last) begin
            r_y         <= w_mul_lo;
            r_y_hi      <= w_mul_hi;
            r_flags     <= {w_mul_lo[MSB], (w_prod_nxt == '0), (w_mul_hi != '0), (w_mul_hi != '0)};
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_hi      = r_y_hi;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=8 with directed and random stimulus.
module tb_alu_pipe;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [7:0] y_hi;
    logic [3:0] flags;

    int          errors = 0;
    int          checks = 0;
    int          m_acc  = 0;
    logic [19:0] exp_q[$];
    logic        bp_en  = 1'b0;

    alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .flags     (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode rules, returns {y, y_hi, flags}.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, sa, sb, sacc, r, hi, s;
        logic c, v, undef;
        logic [3:0] f;
        logic [7:0] ry, rh;
        ia = a; ib = b; sa = $signed(a); sb = $signed(b);
        r = 0; hi = 0; c = 0; v = 0; undef = 0;
        case (op)
            4'd0:  r = 0;
            4'd1:  r = ia & ib;
            4'd2:  r = ia | ib;
            4'd3:  r = ia ^ ib;
            4'd4: begin
                s = ia + ib; r = s % 256; c = (s > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd5: begin
                r = (ia - ib + 256) % 256; c = (ia < ib);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd6:  r = 255 - ia;
            4'd7:  r = 255;
            4'd8: begin
                s = ia * ib; r = s % 256; hi = s / 256; c = (hi != 0); v = c;
            end
            4'd9: begin
                sacc = (m_acc > 127) ? m_acc - 256 : m_acc;
                s = m_acc + ia; r = s % 256; c = (s > 255);
                v = (sacc + sa > 127) || (sacc + sa < -128);
                m_acc = r;
            end
            4'd10: begin
                r = m_acc; m_acc = 0;
            end
            4'd11: r = (ia << (ib % 8)) % 256;
            4'd12: r = ia >> (ib % 8);
            default: undef = 1;
        endcase
        ry = r[7:0];
        rh = hi[7:0];
        if (undef) f = 4'b0001;
        else       f = {(r >= 128), (r == 0 && hi == 0), c, v};
        return {ry, rh, f};
    endfunction

    // Present one request and hold it until accepted; expected result is queued at acceptance.
    task automatic issue(input logic [3:0] op, input logic [7:0] op_a, input logic [7:0] op_b);
        logic accepted;
        accepted = 1'b0;
        sel = op; A = op_a; B = op_b; in_valid = 1'b1;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(op, op_a, op_b));
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compares every consumed result against the scoreboard and checks stability under backpressure.
    initial begin : monitor
        logic [19:0] e;
        logic [19:0] held;
        logic        hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (hold && out_valid) chk("hold_stable", {y, y_hi, flags}, held);
            hold = out_valid && !out_ready;
            held = {y, y_hi, flags};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {y, y_hi, flags}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", y, e[19:12]);
                    chk("y_hi", y_hi, e[11:4]);
                    chk("flags", flags, e[3:0]);
                end
            end
        end
    end

    // Random backpressure on out_ready while enabled.
    initial begin : backpressure
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_y_hi", y_hi, 0);
        chk("rst_flags", flags, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD FF+01: zero result with carry, valid for exactly one cycle.
        issue(4'b0100, 8'hFF, 8'h01);
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        @(negedge clk);
        chk("add_valid_one_cycle", out_valid, 0);
        @(posedge clk); #1;

        // MUL 200*3: eight busy cycles, then the result.
        issue(4'b1000, 8'd200, 8'd3);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (!in_ready) n++;
        end
        chk("mul_busy_cycles", n, 8);
        chk("mul_out_valid", out_valid, 1);
        chk("mul_ready_after", in_ready, 1);
        @(posedge clk); #1;

        // Accumulator sequence.
        issue(4'b1001, 8'd5, 8'd0);
        issue(4'b1001, 8'd5, 8'd0);
        issue(4'b1001, 8'd5, 8'd0);
        issue(4'b1010, 8'd0, 8'd0);
        issue(4'b1001, 8'd1, 8'd0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: SUB result held five cycles, then back-to-back AND.
        out_ready = 1'b0;
        issue(4'b0101, 8'h10, 8'h20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_valid", out_valid, 1);
            chk("held_y", y, 8'hF0);
            chk("held_flags", flags, 4'b1010);
            chk("held_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'b0001, 8'hF0, 8'h3C);
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        @(posedge clk); #1;

        // Undefined opcode and masked shift amount.
        issue(4'b1110, 8'hAA, 8'h55);
        issue(4'b1011, 8'h81, 8'h09);
        issue(4'b1100, 8'h81, 8'h00);

        // Reset in the middle of a multiply.
        issue(4'b0100, 8'd3, 8'd4);
        issue(4'b1001, 8'd9, 8'd0);
        issue(4'b1000, 8'd200, 8'd3);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_y", y, 0);
        chk("arst_y_hi", y_hi, 0);
        chk("arst_flags", flags, 0);
        chk("arst_out_valid", out_valid, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        m_acc = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_in_ready", in_ready, 1);
        issue(4'b1001, 8'd1, 8'd0);
        repeat (2) @(posedge clk);
        #1;

        // Random operations with random backpressure and idle gaps.
        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
